// File: rtl/reg_wb_queue.sv
// In-order write-back queue merging load and ALU results into a single register-file write port.
// Also reports pending-write hazards for the two source registers of the instruction in decode.
module reg_wb_queue #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_mem_valid,
  input  logic [ADDR_WIDTH-1:0]    i_mem_addr,
  input  logic [DATA_WIDTH-1:0]    i_mem_data,
  output logic                     o_mem_ready,
  input  logic                     i_alu_valid,
  input  logic [ADDR_WIDTH-1:0]    i_alu_addr,
  input  logic [DATA_WIDTH-1:0]    i_alu_data,
  output logic                     o_alu_ready,
  input  logic                     i_rf_hold,
  output logic                     o_rf_wrt_en,
  output logic [ADDR_WIDTH-1:0]    o_rf_addrD,
  output logic [DATA_WIDTH-1:0]    o_rf_d,
  input  logic [ADDR_WIDTH-1:0]    i_chk_addrA,
  input  logic [ADDR_WIDTH-1:0]    i_chk_addrB,
  output logic                     o_pend_a,
  output logic                     o_pend_b,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [PtrW-1:0]       r_rd_ptr;
  logic [PtrW-1:0]       r_wr_ptr;
  logic [CntW-1:0]       r_count;

  logic [CntW-1:0]       w_free;
  logic                  w_mem_push;
  logic                  w_alu_push;
  logic                  w_pop;
  logic [PtrW-1:0]       w_alu_slot;
  logic [DEPTH-1:0]      w_occ;

  // Free space ignores a same-cycle pop so readiness never depends on rf_hold.
  assign w_free      = CntW'(DEPTH) - r_count;
  assign o_mem_ready = (w_free >= CntW'(1));
  assign o_alu_ready = (w_free >= CntW'(2)) || ((w_free == CntW'(1)) && !i_mem_valid);

  assign w_mem_push  = i_mem_valid && o_mem_ready;
  assign w_alu_push  = i_alu_valid && o_alu_ready;
  assign w_pop       = (r_count != '0) && !i_rf_hold;

  // The load is the older instruction, so it takes the first free slot.
  assign w_alu_slot  = r_wr_ptr + PtrW'(w_mem_push);

  assign o_rf_wrt_en = w_pop;
  assign o_rf_addrD  = r_addr[r_rd_ptr];
  assign o_rf_d      = r_data[r_rd_ptr];
  assign o_count     = r_count;

  always_ff @(posedge clk) begin
    if (w_mem_push) begin
      r_addr[r_wr_ptr] <= i_mem_addr;
      r_data[r_wr_ptr] <= i_mem_data;
    end
    if (w_alu_push) begin
      r_addr[w_alu_slot] <= i_alu_addr;
      r_data[w_alu_slot] <= i_alu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + PtrW'(w_pop);
      r_wr_ptr <= r_wr_ptr + PtrW'(w_mem_push) + PtrW'(w_alu_push);
      r_count  <= r_count + CntW'(w_mem_push) + CntW'(w_alu_push) - CntW'(w_pop);
    end
  end

  // Entry i is occupied when its distance from the head is below the count.
  always_comb begin
    w_occ    = '0;
    o_pend_a = 1'b0;
    o_pend_b = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_occ[i] = ({1'b0, PtrW'(PtrW'(i) - r_rd_ptr)} < r_count);
      if (w_occ[i] && (r_addr[i] == i_chk_addrA)) o_pend_a = 1'b1;
      if (w_occ[i] && (r_addr[i] == i_chk_addrB)) o_pend_b = 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_wb_queue.sv
// Directed bench for reg_wb_queue: a queue-based reference model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_reg_wb_queue;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_valid, alu_valid, rf_hold;
  logic [AW-1:0] mem_addr, alu_addr, chk_a, chk_b;
  logic [DW-1:0] mem_data, alu_data;
  logic          mem_ready, alu_ready, wrt_en, pend_a, pend_b;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] d;
  logic [2:0]    count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reg_wb_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_mem_valid (mem_valid),
    .i_mem_addr  (mem_addr),
    .i_mem_data  (mem_data),
    .o_mem_ready (mem_ready),
    .i_alu_valid (alu_valid),
    .i_alu_addr  (alu_addr),
    .i_alu_data  (alu_data),
    .o_alu_ready (alu_ready),
    .i_rf_hold   (rf_hold),
    .o_rf_wrt_en (wrt_en),
    .o_rf_addrD  (addr_d),
    .o_rf_d      (d),
    .i_chk_addrA (chk_a),
    .i_chk_addrB (chk_b),
    .o_pend_a    (pend_a),
    .o_pend_b    (pend_b),
    .o_count     (count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of pending writes.
  logic [AW-1:0] q_addr [$];
  logic [DW-1:0] q_data [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_addr.delete();
      q_data.delete();
    end else begin
      int  sz, fr;
      bit  pop, macc, aacc;
      sz   = q_addr.size();
      fr   = DEPTH - sz;
      pop  = (sz != 0) && !rf_hold;
      macc = mem_valid && (fr >= 1);
      aacc = alu_valid && ((fr >= 2) || (fr == 1 && !mem_valid));
      if (pop) begin
        void'(q_addr.pop_front());
        void'(q_data.pop_front());
      end
      if (macc) begin
        q_addr.push_back(mem_addr);
        q_data.push_back(mem_data);
      end
      if (aacc) begin
        q_addr.push_back(alu_addr);
        q_data.push_back(alu_data);
      end
    end
  end

  always @(negedge clk) begin
    int sz, fr;
    bit en, pa, pb;
    sz = q_addr.size();
    fr = DEPTH - sz;
    en = (sz != 0) && !rf_hold;
    pa = 1'b0;
    pb = 1'b0;
    foreach (q_addr[k]) begin
      if (q_addr[k] == chk_a) pa = 1'b1;
      if (q_addr[k] == chk_b) pb = 1'b1;
    end
    chk("cmp_count", 64'(count), 64'(sz));
    chk("cmp_wrt_en", 64'(wrt_en), 64'(en));
    if (en) begin
      chk("cmp_addrD", 64'(addr_d), 64'(q_addr[0]));
      chk("cmp_d", 64'(d), 64'(q_data[0]));
    end
    chk("cmp_mem_ready", 64'(mem_ready), 64'(fr >= 1));
    chk("cmp_alu_ready", 64'(alu_ready), 64'((fr >= 2) || (fr == 1 && !mem_valid)));
    chk("cmp_pend_a", 64'(pa), 64'(pend_a));
    chk("cmp_pend_b", 64'(pb), 64'(pend_b));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] x);
    mem_valid = v;
    mem_addr  = a;
    mem_data  = x;
  endtask

  task automatic set_alu(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] x);
    alu_valid = v;
    alu_addr  = a;
    alu_data  = x;
  endtask

  initial begin
    rst_n   = 1'b0;
    rf_hold = 1'b0;
    chk_a   = '0;
    chk_b   = '0;
    set_mem(1'b0, '0, '0);
    set_alu(1'b0, '0, '0);
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_wrt_en", 64'(wrt_en), 64'd0);
    chk("rst_mem_ready", 64'(mem_ready), 64'd1);
    chk("rst_alu_ready", 64'(alu_ready), 64'd1);
    chk("rst_pend", 64'({pend_a, pend_b}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single ALU write, one-cycle latency.
    set_alu(1'b1, 5'd3, 32'h1234);
    step();
    chk("alu1_wrt_en", 64'(wrt_en), 64'd1);
    chk("alu1_addrD", 64'(addr_d), 64'd3);
    chk("alu1_d", 64'(d), 64'h1234);
    chk("alu1_count", 64'(count), 64'd1);
    set_alu(1'b0, '0, '0);
    step();
    chk("alu1_drained", 64'(count), 64'd0);
    chk("alu1_wrt_off", 64'(wrt_en), 64'd0);

    // Address zero is an ordinary destination.
    set_alu(1'b1, 5'd0, 32'hdead);
    step();
    chk("zero_addrD", 64'(addr_d), 64'd0);
    chk("zero_d", 64'(d), 64'hdead);
    chk("zero_pend_b", 64'(pend_b), 64'd1);
    set_alu(1'b0, '0, '0);
    step();
    chk("zero_pend_off", 64'(pend_b), 64'd0);

    // Same-cycle load and ALU to one register: load first, last write wins.
    chk_a = 5'd5;
    set_mem(1'b1, 5'd5, 32'hAA);
    set_alu(1'b1, 5'd5, 32'hBB);
    step();
    set_mem(1'b0, '0, '0);
    set_alu(1'b0, '0, '0);
    chk("dual_first_d", 64'(d), 64'hAA);
    chk("dual_count", 64'(count), 64'd2);
    chk("dual_pend_a1", 64'(pend_a), 64'd1);
    step();
    chk("dual_second_d", 64'(d), 64'hBB);
    chk("dual_pend_a2", 64'(pend_a), 64'd1);
    step();
    chk("dual_pend_a_off", 64'(pend_a), 64'd0);
    chk("dual_count_end", 64'(count), 64'd0);

    // Fill under hold; overflow request ignored; drain in order.
    rf_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_alu(1'b1, AW'(i + 1), 32'h100 + DW'(i));
      step();
    end
    set_alu(1'b0, '0, '0);
    #1;
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'({mem_ready, alu_ready}), 64'd0);
    chk("full_hold_addrD", 64'(addr_d), 64'd1);
    set_alu(1'b1, 5'd9, 32'h999);
    step();
    set_alu(1'b0, '0, '0);
    chk("full_ignored", 64'(count), 64'd4);
    chk("full_hold_d", 64'(d), 64'h100);
    rf_hold = 1'b0;
    #1;
    chk("drain0_d", 64'(d), 64'h100);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("drain_d", 64'(d), 64'h100 + 64'(i));
    end
    step();
    chk("drain_empty", 64'(count), 64'd0);

    // One slot left with both requesting: only the load is taken.
    rf_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_alu(1'b1, AW'(16 + i), 32'h200 + DW'(i));
      step();
    end
    set_mem(1'b1, 5'd7, 32'h77);
    set_alu(1'b1, 5'd8, 32'h88);
    #1;
    chk("one_free_alu_ready", 64'(alu_ready), 64'd0);
    chk("one_free_mem_ready", 64'(mem_ready), 64'd1);
    step();
    set_mem(1'b0, '0, '0);
    set_alu(1'b0, '0, '0);
    chk("one_free_count", 64'(count), 64'd4);
    rf_hold = 1'b0;
    step();
    chk("one_free_pop", 64'(count), 64'd3);
    set_mem(1'b1, 5'd7, 32'h70);
    set_alu(1'b1, 5'd8, 32'h80);
    #1;
    chk("pop_same_alu_ready", 64'(alu_ready), 64'd0);
    step();
    set_mem(1'b0, '0, '0);
    set_alu(1'b0, '0, '0);
    chk("pop_same_count", 64'(count), 64'd3);
    repeat (4) step();
    chk("pop_same_empty", 64'(count), 64'd0);

    // Streaming one push per cycle across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      set_alu(1'b1, AW'(i + 1), 32'h300 + DW'(i));
      step();
      chk("stream_count", 64'(count), 64'd1);
      chk("stream_d", 64'(d), 64'h300 + 64'(i));
    end
    set_alu(1'b0, '0, '0);
    step();
    chk("stream_empty", 64'(count), 64'd0);

    // Asynchronous reset mid-cycle discards queued entries.
    rf_hold = 1'b1;
    chk_a   = 5'd12;
    for (int i = 0; i < 3; i++) begin
      set_alu(1'b1, AW'(10 + i), 32'h400 + DW'(i));
      step();
    end
    set_alu(1'b0, '0, '0);
    rf_hold = 1'b0;
    #1;
    chk("pre_rst_wrt_en", 64'(wrt_en), 64'd1);
    chk("pre_rst_pend_a", 64'(pend_a), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_wrt_en", 64'(wrt_en), 64'd0);
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_pend_a", 64'(pend_a), 64'd0);
    chk("async_rst_ready", 64'({mem_ready, alu_ready}), 64'd3);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("post_rst_wrt_en", 64'(wrt_en), 64'd0);
    chk("post_rst_count", 64'(count), 64'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
